// File: rtl/iexu_result_arbiter_if.sv
// ----------------------------------------------------------------------------
// iexu_result_arbiter_if
//
// Bundle between the integer execution unit's functional units, the result
// arbiter and the commit stage.
//
//   ch_valid_i    per-channel result valid (functional units -> arbiter)
//   ch_result_i   per-channel result, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_ipacket_i  per-channel instruction packet, same packing as ch_result_i
//   ch_ready_o    per-channel FIFO has room (arbiter -> issue logic)
//   result_o      arbitrated result, zero when data_valid_o is low
//   ipacket_o     arbitrated instruction packet, zero when data_valid_o is low
//   data_valid_o  output register holds a valid entry
//   grant_o       channel index of the current output entry, zero when invalid
//   ready_i       commit stage accepts the output entry this cycle
//
// Modports: master = the environment (units + commit stage),
//           slave  = the arbiter itself.
// ----------------------------------------------------------------------------
interface iexu_result_arbiter_if #(
    parameter int CHANNELS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int PACKET_WIDTH = 64
);
    localparam int GRANT_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]              ch_valid_i;
    logic [CHANNELS*DATA_WIDTH-1:0]   ch_result_i;
    logic [CHANNELS*PACKET_WIDTH-1:0] ch_ipacket_i;
    logic [CHANNELS-1:0]              ch_ready_o;
    logic [DATA_WIDTH-1:0]            result_o;
    logic [PACKET_WIDTH-1:0]          ipacket_o;
    logic                             data_valid_o;
    logic [GRANT_W-1:0]               grant_o;
    logic                             ready_i;

    modport master (
        output ch_valid_i, ch_result_i, ch_ipacket_i, ready_i,
        input  ch_ready_o, result_o, ipacket_o, data_valid_o, grant_o
    );

    modport slave (
        input  ch_valid_i, ch_result_i, ch_ipacket_i, ready_i,
        output ch_ready_o, result_o, ipacket_o, data_valid_o, grant_o
    );
endinterface

// File: rtl/iexu_result_arbiter.sv
// ----------------------------------------------------------------------------
// iexu_result_arbiter
//
// Writeback arbiter for the integer execution unit. Each of CHANNELS
// functional units pushes results into its own small FIFO; a round-robin
// arbiter picks one non-empty FIFO per load cycle and moves its head into a
// single output register that talks valid/ready to the commit stage.
//
// Ports:
//   clk_i     clock
//   rst_n_i   asynchronous active-low reset, discards every queued entry
//   clk_en_i  global enable; low freezes all state
//   bus       iexu_result_arbiter_if.slave (channel inputs, ch_ready_o,
//             result/ipacket/data_valid/grant outputs, ready_i)
//
// Build macros:
//   IEXU_ARBITER_BYPASS_EN  an empty channel may bid with its live input and
//                           go straight to the output register (1-cycle
//                           minimum latency instead of 2).
//   ASSERTIONS              flag results offered to a full FIFO (dropped).
// ----------------------------------------------------------------------------
module iexu_result_arbiter #(
    parameter int CHANNELS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int PACKET_WIDTH = 64,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    iexu_result_arbiter_if.slave  bus
);
    localparam int GRANT_W = $clog2(CHANNELS);
    localparam int SCAN_W  = GRANT_W + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Per-channel view shared between the FIFOs and the arbiter
    logic [CHANNELS-1:0]     fifo_nonempty;
    logic [CHANNELS-1:0]     ch_ready;
    logic [CHANNELS-1:0]     candidate;
    logic [CHANNELS-1:0]     push;
    logic [CHANNELS-1:0]     pop;
    logic [CHANNELS-1:0]     bypass_take;
    logic [DATA_WIDTH-1:0]   cand_result  [CHANNELS];
    logic [PACKET_WIDTH-1:0] cand_ipacket [CHANNELS];

    // Arbiter and output register
    logic [GRANT_W-1:0]      rr_ptr_reg;
    logic [GRANT_W-1:0]      rr_ptr_next;
    logic                    grant_found;
    logic [GRANT_W-1:0]      winner;
    logic [DATA_WIDTH-1:0]   win_result;
    logic [PACKET_WIDTH-1:0] win_ipacket;
    logic                    load_en;
    logic                    grant_fire;

    logic                    data_valid_reg;
    logic [DATA_WIDTH-1:0]   result_reg;
    logic [PACKET_WIDTH-1:0] ipacket_reg;
    logic [GRANT_W-1:0]      grant_reg;

    // The output register refills whenever it is empty or being drained.
    assign load_en    = clk_en_i & (~data_valid_reg | bus.ready_i);
    assign grant_fire = load_en & grant_found;

    // ------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0]   data_mem [FIFO_DEPTH];
            logic [PACKET_WIDTH-1:0] pkt_mem  [FIFO_DEPTH];
            logic [PTR_W-1:0]        wr_ptr_reg;
            logic [PTR_W-1:0]        rd_ptr_reg;
            logic [CNT_W-1:0]        count_reg;
            logic [CNT_W-1:0]        count_next;
            logic                    in_valid;
            logic [DATA_WIDTH-1:0]   in_result;
            logic [PACKET_WIDTH-1:0] in_ipacket;
            logic [DATA_WIDTH-1:0]   head_result;
            logic [PACKET_WIDTH-1:0] head_ipacket;
            logic                    is_winner;

            assign in_valid   = bus.ch_valid_i[gi];
            assign in_result  = bus.ch_result_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_ipacket = bus.ch_ipacket_i[gi*PACKET_WIDTH +: PACKET_WIDTH];

            // Ready depends only on the registered count, so the issue
            // logic never sees a combinational path from ready_i.
            assign fifo_nonempty[gi] = (count_reg != '0);
            assign ch_ready[gi]      = (count_reg != CNT_FULL);

            // Head is read asynchronously: an entry written at one edge
            // is visible to the arbiter during the very next cycle.
            assign head_result  = data_mem[rd_ptr_reg];
            assign head_ipacket = pkt_mem[rd_ptr_reg];

            assign is_winner = grant_fire && (winner == GRANT_W'(gi));

`ifdef IEXU_ARBITER_BYPASS_EN
            // An empty FIFO lets its live input bid directly; if it wins,
            // the entry skips the FIFO entirely.
            assign candidate[gi]    = fifo_nonempty[gi] | in_valid;
            assign cand_result[gi]  = fifo_nonempty[gi] ? head_result  : in_result;
            assign cand_ipacket[gi] = fifo_nonempty[gi] ? head_ipacket : in_ipacket;
            assign bypass_take[gi]  = is_winner & ~fifo_nonempty[gi];
`else
            assign candidate[gi]    = fifo_nonempty[gi];
            assign cand_result[gi]  = head_result;
            assign cand_ipacket[gi] = head_ipacket;
            assign bypass_take[gi]  = 1'b0;
`endif

            assign push[gi] = clk_en_i & in_valid & ch_ready[gi] & ~bypass_take[gi];
            assign pop[gi]  = is_winner & fifo_nonempty[gi];

            always_comb begin
                count_next = count_reg;
                case ({push[gi], pop[gi]})
                    2'b10:   count_next = count_reg + CNT_W'(1);
                    2'b01:   count_next = count_reg - CNT_W'(1);
                    default: count_next = count_reg;
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_next;
                end
            end

            // Storage carries no reset; a zero count hides stale contents.
            always_ff @(posedge clk_i) begin
                if (push[gi]) begin
                    data_mem[wr_ptr_reg] <= in_result;
                    pkt_mem[wr_ptr_reg]  <= in_ipacket;
                end
            end

`ifdef ASSERTIONS
            a_no_drop: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                !(clk_en_i && in_valid && !ch_ready[gi]))
                else $error("channel %0d: result offered while FIFO full, entry dropped", gi);
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search starting at rr_ptr_reg, wrapping modulo CHANNELS.
    // The scan index has one spare bit so the wrap works for any count.
    // ------------------------------------------------------------------
    always_comb begin
        logic [SCAN_W-1:0] scan_sum;
        grant_found = 1'b0;
        winner      = '0;
        scan_sum    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + SCAN_W'(k);
            if (scan_sum >= SCAN_W'(CHANNELS)) begin
                scan_sum = scan_sum - SCAN_W'(CHANNELS);
            end
            if (!grant_found && candidate[scan_sum[GRANT_W-1:0]]) begin
                grant_found = 1'b1;
                winner      = scan_sum[GRANT_W-1:0];
            end
        end
    end

    always_comb begin
        win_result  = '0;
        win_ipacket = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (winner == GRANT_W'(c)) begin
                win_result  = cand_result[c];
                win_ipacket = cand_ipacket[c];
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_fire) begin
            rr_ptr_next = (winner == GRANT_W'(CHANNELS - 1)) ? '0 : winner + GRANT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output register; payload is stored as zero whenever nothing is
    // granted so downstream logic can OR several result buses together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_reg     <= '0;
            data_valid_reg <= 1'b0;
            result_reg     <= '0;
            ipacket_reg    <= '0;
            grant_reg      <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (load_en) begin
                data_valid_reg <= grant_found;
                result_reg     <= grant_found ? win_result  : '0;
                ipacket_reg    <= grant_found ? win_ipacket : '0;
                grant_reg      <= grant_found ? winner      : '0;
            end
        end
    end

    assign bus.ch_ready_o   = ch_ready;
    assign bus.data_valid_o = data_valid_reg;
    assign bus.result_o     = result_reg;
    assign bus.ipacket_o    = ipacket_reg;
    assign bus.grant_o      = grant_reg;

endmodule

// File: tb/tb_iexu_result_arbiter.sv
// ----------------------------------------------------------------------------
// tb_iexu_result_arbiter
//
// Directed bench for iexu_result_arbiter (4 channels, 32-bit results,
// 64-bit packets, depth-2 FIFOs). Inputs change and outputs are sampled on
// the falling clock edge; the design acts on the rising edge.
// Expected latency follows IEXU_ARBITER_BYPASS_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_iexu_result_arbiter;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int PW = 64;
    localparam int FD = 2;
`ifdef IEXU_ARBITER_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk_i;
    logic rst_n_i;
    logic clk_en_i;

    int tests_run;
    int tests_failed;

    iexu_result_arbiter_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .PACKET_WIDTH(PW)) bus ();

    iexu_result_arbiter #(
        .CHANNELS     (CH),
        .DATA_WIDTH   (DW),
        .PACKET_WIDTH (PW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clk_en_i (clk_en_i),
        .bus      (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, act);
        end
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [DW-1:0] r, input logic [PW-1:0] p);
        bus.ch_valid_i[ch]            = v;
        bus.ch_result_i[ch*DW +: DW]  = r;
        bus.ch_ipacket_i[ch*PW +: PW] = p;
    endtask

    task automatic clear_inputs();
        bus.ch_valid_i   = '0;
        bus.ch_result_i  = '0;
        bus.ch_ipacket_i = '0;
    endtask

    // Ends on a falling edge with reset released; next rising edge is live.
    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i     = 1'b0;
        clk_en_i    = 1'b1;
        bus.ready_i = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] seq_vals [4];
        logic [DW-1:0] exp_r;
        logic [63:0]   exp_g;
        logic          exp_v;

        tests_run    = 0;
        tests_failed = 0;
        rst_n_i      = 1'b0;
        clk_en_i     = 1'b1;
        bus.ready_i  = 1'b1;
        clear_inputs();

        // ---------------- reset state ----------------
        do_reset();
        check_eq("rst_valid",   64'(bus.data_valid_o), 64'd0);
        check_eq("rst_ready",   64'(bus.ch_ready_o),   64'hF);
        check_eq("rst_result",  64'(bus.result_o),     64'd0);
        check_eq("rst_ipacket", bus.ipacket_o,         64'd0);
        check_eq("rst_grant",   64'(bus.grant_o),      64'd0);

        // ---------------- 1: single result, latency ----------------
        set_ch(2, 1'b1, 32'hDEADBEEF, 64'h0000_0002_CAFE_0001);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            clear_inputs();
            exp_v = (k == LAT);
            check_eq($sformatf("t1_valid_c%0d", k),  64'(bus.data_valid_o), 64'(exp_v));
            check_eq($sformatf("t1_result_c%0d", k), 64'(bus.result_o), exp_v ? 64'hDEADBEEF : 64'd0);
            check_eq($sformatf("t1_grant_c%0d", k),  64'(bus.grant_o),  exp_v ? 64'd2 : 64'd0);
        end

        // ---------------- 2: four simultaneous results ----------------
        do_reset();
        for (int c = 0; c < CH; c++) begin
            set_ch(c, 1'b1, DW'(c + 1), PW'(64'h100 + c));
        end
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk_i);
            clear_inputs();
            exp_v = (k >= LAT) && (k - LAT < 4);
            check_eq($sformatf("t2_valid_c%0d", k),  64'(bus.data_valid_o), 64'(exp_v));
            check_eq($sformatf("t2_result_c%0d", k), 64'(bus.result_o),
                     exp_v ? 64'(k - LAT + 1) : 64'd0);
            check_eq($sformatf("t2_grant_c%0d", k),  64'(bus.grant_o),
                     exp_v ? 64'(k - LAT) : 64'd0);
            check_eq($sformatf("t2_ipkt_c%0d", k),   bus.ipacket_o,
                     exp_v ? 64'(64'h100 + (k - LAT)) : 64'd0);
        end

        // ---------------- 3: backpressure, drop on full ----------------
        do_reset();
        bus.ready_i = 1'b0;
        seq_vals[0] = 32'hA;
        seq_vals[1] = 32'hB;
        seq_vals[2] = 32'hC;
        seq_vals[3] = 32'hD;
        for (int j = 0; j < 4; j++) begin
            if (j != 0) @(negedge clk_i);
            check_eq($sformatf("t3_ready0_before_%0d", j), 64'(bus.ch_ready_o[0]), 64'(j != 3));
            set_ch(0, 1'b1, seq_vals[j], 64'(j));
        end
        @(negedge clk_i);
        clear_inputs();
        check_eq("t3_ready0_full", 64'(bus.ch_ready_o[0]), 64'd0);
        check_eq("t3_hold_valid",  64'(bus.data_valid_o),  64'd1);
        check_eq("t3_hold_result", 64'(bus.result_o),      64'hA);
        bus.ready_i = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk_i);
            exp_v = (j < 3);
            check_eq($sformatf("t3_drain_valid_%0d", j),  64'(bus.data_valid_o), 64'(exp_v));
            check_eq($sformatf("t3_drain_result_%0d", j), 64'(bus.result_o),
                     exp_v ? 64'(seq_vals[j]) : 64'd0);
        end

        // ---------------- 4: two busy channels, fairness ----------------
        do_reset();
        for (int k = 1; k <= LAT + 5; k++) begin
            set_ch(0, 1'b1, {8'h00, 24'(k)}, 64'(k));
            set_ch(3, 1'b1, {8'h03, 24'(k)}, 64'(k));
            @(negedge clk_i);
            exp_v = (k >= LAT);
            exp_g = exp_v ? ((((k - LAT) % 2) == 0) ? 64'd0 : 64'd3) : 64'd0;
            check_eq($sformatf("t4_valid_c%0d", k), 64'(bus.data_valid_o), 64'(exp_v));
            check_eq($sformatf("t4_grant_c%0d", k), 64'(bus.grant_o), exp_g);
            check_eq($sformatf("t4_src_c%0d", k),   64'(bus.result_o[31:24]), exp_g);
        end
        clear_inputs();

        // ---------------- 5: asynchronous reset mid-operation ----------------
        do_reset();
        bus.ready_i = 1'b0;
        set_ch(0, 1'b1, 32'h5A5A_0000, 64'h50);
        set_ch(1, 1'b1, 32'h5A5A_0001, 64'h51);
        @(negedge clk_i);
        clear_inputs();
        @(negedge clk_i);
        check_eq("t5_pre_valid",  64'(bus.data_valid_o), 64'd1);
        check_eq("t5_pre_result", 64'(bus.result_o),     64'h5A5A_0000);
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("t5_async_valid",  64'(bus.data_valid_o), 64'd0);
        check_eq("t5_async_ready",  64'(bus.ch_ready_o),   64'hF);
        check_eq("t5_async_result", 64'(bus.result_o),     64'd0);
        #1 rst_n_i = 1'b1;
        bus.ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            check_eq($sformatf("t5_post_valid_c%0d", k), 64'(bus.data_valid_o), 64'd0);
        end

        // ---------------- 6: clock enable freeze ----------------
        do_reset();
        bus.ready_i = 1'b0;
        set_ch(1, 1'b1, 32'h0000_1111, 64'h61);
        @(negedge clk_i);
        set_ch(1, 1'b1, 32'h0000_2222, 64'h62);
        @(negedge clk_i);
        clear_inputs();
        @(negedge clk_i);
        check_eq("t6_pre_result", 64'(bus.result_o),  64'h1111);
        check_eq("t6_pre_ipkt",   bus.ipacket_o,      64'h61);
        clk_en_i    = 1'b0;
        bus.ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            check_eq($sformatf("t6_hold_valid_c%0d", k),  64'(bus.data_valid_o), 64'd1);
            check_eq($sformatf("t6_hold_result_c%0d", k), 64'(bus.result_o),     64'h1111);
            check_eq($sformatf("t6_hold_grant_c%0d", k),  64'(bus.grant_o),      64'd1);
        end
        clk_en_i = 1'b1;
        @(negedge clk_i);
        check_eq("t6_next_valid",  64'(bus.data_valid_o), 64'd1);
        check_eq("t6_next_result", 64'(bus.result_o),     64'h2222);
        @(negedge clk_i);
        check_eq("t6_empty_valid", 64'(bus.data_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
